aqalu_trace_recorder: RTL and testbench

Hardware counterpart of the AQALU vector bench: observes the operand, opcode and result buses around an AQALU instance and emits packed trace records. Record fields are A, B, opcode, output and seconds-held, in the same field order as the text test-vector format, so captured traces replay directly as vector files. Sits beside the AQALU in the lab build. Records drain to a host link through a small FIFO with a valid/ready handshake.

---
 rtl/aqalu_trace_recorder.sv | 147 ++++++++++++++
 tb/tb_aqalu_trace_recorder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aqalu_trace_recorder.sv
// AQALU trace recorder: turns held operand/opcode tuples into
// vector-format records and queues them for a host link.
module aqalu_trace_recorder #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int SEC_W         = 8,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              arm,
  input  logic              flush,
  input  logic [1:0]        A,
  input  logic [1:0]        B,
  input  logic [3:0]        Opcode,
  input  logic [7:0]        Output,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [15+SEC_W:0] rec_data,
  output logic              overflow,
  output logic [7:0]        drop_count,
  output logic              busy
);

  localparam int RW = 16 + SEC_W;
  localparam int TW = (TICKS_PER_SEC > 1) ?
                      $clog2(TICKS_PER_SEC) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0]    TMAX  = TW'(TICKS_PER_SEC - 1);
  localparam logic [SEC_W-1:0] SMAX  = '1;
  localparam logic [AW:0]      DEPTH = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t           r_state;
  logic [7:0]       r_cur;
  logic [7:0]       r_last;
  logic [TW-1:0]    r_tick;
  logic [SEC_W-1:0] r_sec;
  logic [RW-1:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_cnt;
  logic             r_ovf;
  logic [7:0]       r_drops;

  logic [7:0]    w_tuple;
  logic          w_run;
  logic          w_chg;
  logic          w_wrap;
  logic          w_sat;
  logic          w_push;
  logic          w_pop;
  logic          w_wr;
  logic          w_drop;
  logic [RW-1:0] w_rec;

  assign w_tuple = {A, B, Opcode};
  assign w_run   = (r_state == S_RUN);
  assign w_chg   = (w_tuple != r_cur);
  assign w_wrap  = (r_tick == TMAX);
  assign w_sat   = (r_sec == SMAX);
  // Any event, including the saturation roll, yields a single record.
  assign w_push  = w_run &
                   (!arm | w_chg | flush | (w_wrap & w_sat));
  assign w_rec   = {r_cur, r_last, r_sec};
  assign w_pop   = rec_valid & rec_ready;
  assign w_wr    = w_push & ((r_cnt != DEPTH) | w_pop);
  assign w_drop  = w_push & !w_wr;

  assign rec_valid  = (r_cnt != '0);
  assign rec_data   = rec_valid ? r_mem[r_rp] : '0;
  assign overflow   = r_ovf;
  assign drop_count = r_drops;
  assign busy       = w_run | rec_valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cur   <= '0;
      r_last  <= '0;
      r_tick  <= '0;
      r_sec   <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_drops <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        r_mem[i] <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wp] <= w_rec;
        r_wp        <= r_wp + AW'(1);
      end
      if (w_pop)
        r_rp <= r_rp + AW'(1);
      unique case ({w_wr, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (w_drop) begin
        r_ovf   <= 1'b1;
        r_drops <= r_drops + 8'(r_drops != 8'hFF);
      end

      unique case (r_state)
        S_IDLE: begin
          if (arm) begin
            r_state <= S_RUN;
            r_cur   <= w_tuple;
            r_last  <= Output;
            r_tick  <= '0;
            r_sec   <= '0;
            r_ovf   <= 1'b0;
            r_drops <= '0;
          end
        end
        S_RUN: begin
          r_last <= Output;
          if (!arm) begin
            r_state <= S_IDLE;
            r_tick  <= '0;
            r_sec   <= '0;
          end else if (w_chg) begin
            r_cur  <= w_tuple;
            r_tick <= '0;
            r_sec  <= '0;
          end else if (flush) begin
            r_tick <= '0;
            r_sec  <= '0;
          end else if (w_wrap) begin
            r_tick <= '0;
            r_sec  <= w_sat ? '0 : r_sec + SEC_W'(1);
          end else begin
            r_tick <= r_tick + TW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aqalu_trace_recorder.sv
// Directed bench for aqalu_trace_recorder: one DUT at 10 ticks/s,
// one at 1 tick/s for the seconds-saturation path.
module tb_aqalu_trace_recorder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        arm = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  A = '0;
  logic [1:0]  B = '0;
  logic [3:0]  Op = '0;
  logic [7:0]  Out = '0;
  logic        rec_ready = 1'b0;

  logic        v10, ov10, b10;
  logic [23:0] d10;
  logic [7:0]  dc10;
  logic        v1, ov1, b1;
  logic [23:0] d1;
  logic [7:0]  dc1;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  aqalu_trace_recorder #(
    .TICKS_PER_SEC(10), .SEC_W(8), .FIFO_DEPTH(4)
  ) u10 (
    .clock(clock), .reset(reset), .arm(arm), .flush(flush),
    .A(A), .B(B), .Opcode(Op), .Output(Out),
    .rec_valid(v10), .rec_ready(rec_ready), .rec_data(d10),
    .overflow(ov10), .drop_count(dc10), .busy(b10)
  );

  aqalu_trace_recorder #(
    .TICKS_PER_SEC(1), .SEC_W(8), .FIFO_DEPTH(4)
  ) u1 (
    .clock(clock), .reset(reset), .arm(arm), .flush(flush),
    .A(A), .B(B), .Opcode(Op), .Output(Out),
    .rec_valid(v1), .rec_ready(rec_ready), .rec_data(d1),
    .overflow(ov1), .drop_count(dc1), .busy(b1)
  );

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    arm = 1'b0;
    flush = 1'b0;
    rec_ready = 1'b0;
    A = '0; B = '0; Op = '0; Out = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    step();
    total++;
    if ({v10, d10, ov10, dc10, b10} !== 35'd0) begin
      bad++;
      $display("FAIL reset_state got v=%b d=%h ov=%b dc=%0d busy=%b exp all 0",
               v10, d10, ov10, dc10, b10);
    end
    arm = 1'b1;
    step();
    Op = 4'd1;
    step();
    Op = 4'd2;
    step();
    total++;
    if (v10 !== 1'b1) begin
      bad++;
      $display("FAIL reset_pre_valid got=%b exp=1", v10);
    end
    #2;
    reset = 1'b0;
    #1;
    total++;
    if ({v10, dc10, b10, d10} !== 34'd0) begin
      bad++;
      $display("FAIL reset_async got v=%b dc=%0d busy=%b d=%h exp 0",
               v10, dc10, b10, d10);
    end
  endtask

  task automatic test_basic;
    do_reset();
    A = 2'd1; B = 2'd2; Op = 4'b0011; Out = 8'h03;
    arm = 1'b1;
    step();
    repeat (34) step();
    total++;
    if (v10 !== 1'b0) begin
      bad++;
      $display("FAIL basic_no_early got=%b exp=0", v10);
    end
    A = 2'd2;
    Out = 8'h55;
    step();
    total++;
    if (v10 !== 1'b1 || d10 !== 24'h630303) begin
      bad++;
      $display("FAIL basic_record got v=%b d=%h exp v=1 d=630303", v10, d10);
    end
  endtask

  task automatic test_saturation;
    do_reset();
    A = 2'd3; B = 2'd0; Op = 4'hF; Out = 8'hAA;
    arm = 1'b1;
    step();
    repeat (255) step();
    total++;
    if (v1 !== 1'b0) begin
      bad++;
      $display("FAIL sat_no_early got=%b exp=0", v1);
    end
    step();
    total++;
    if (v1 !== 1'b1 || d1 !== 24'hCFAAFF) begin
      bad++;
      $display("FAIL sat_255 got v=%b d=%h exp v=1 d=cfaaff", v1, d1);
    end
    repeat (43) step();
    A = 2'd1;
    step();
    total++;
    if (d1 !== 24'hCFAAFF) begin
      bad++;
      $display("FAIL sat_head_hold got=%h exp=cfaaff", d1);
    end
    rec_ready = 1'b1;
    step();
    total++;
    if (v1 !== 1'b1 || d1 !== 24'hCFAA2B) begin
      bad++;
      $display("FAIL sat_43 got v=%b d=%h exp v=1 d=cfaa2b", v1, d1);
    end
    step();
    total++;
    if (v1 !== 1'b0) begin
      bad++;
      $display("FAIL sat_drained got=%b exp=0", v1);
    end
  endtask

  task automatic test_backpressure;
    logic [23:0] exp;
    do_reset();
    Out = 8'h10;
    arm = 1'b1;
    step();
    for (int i = 1; i <= 6; i++) begin
      Op = 4'(i);
      Out = 8'(16 + i);
      step();
    end
    total++;
    if (v10 !== 1'b1 || ov10 !== 1'b1 || dc10 !== 8'd2) begin
      bad++;
      $display("FAIL bp_overflow got v=%b ov=%b dc=%0d exp v=1 ov=1 dc=2",
               v10, ov10, dc10);
    end
    rec_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      exp = {4'h0, 4'(j), 8'(16 + j), 8'h00};
      total++;
      if (v10 !== 1'b1 || d10 !== exp) begin
        bad++;
        $display("FAIL bp_drain%0d got v=%b d=%h exp v=1 d=%h",
                 j, v10, d10, exp);
      end
      step();
    end
    total++;
    if (v10 !== 1'b0 || dc10 !== 8'd2) begin
      bad++;
      $display("FAIL bp_empty got v=%b dc=%0d exp v=0 dc=2", v10, dc10);
    end
  endtask

  task automatic test_flush_disarm;
    do_reset();
    A = 2'd2; B = 2'd1; Op = 4'd5; Out = 8'h77;
    arm = 1'b1;
    step();
    repeat (24) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    total++;
    if (v10 !== 1'b1 || d10 !== 24'h957702) begin
      bad++;
      $display("FAIL flush_record got v=%b d=%h exp v=1 d=957702", v10, d10);
    end
    rec_ready = 1'b1;
    step();
    rec_ready = 1'b0;
    total++;
    if (v10 !== 1'b0) begin
      bad++;
      $display("FAIL flush_single got=%b exp=0", v10);
    end
    repeat (13) step();
    arm = 1'b0;
    Out = 8'h11;
    step();
    total++;
    if (v10 !== 1'b1 || d10 !== 24'h957701 || b10 !== 1'b1) begin
      bad++;
      $display("FAIL disarm_record got v=%b d=%h busy=%b exp v=1 d=957701 busy=1",
               v10, d10, b10);
    end
    rec_ready = 1'b1;
    step();
    total++;
    if (v10 !== 1'b0 || b10 !== 1'b0) begin
      bad++;
      $display("FAIL disarm_idle got v=%b busy=%b exp 0 0", v10, b10);
    end
    rec_ready = 1'b0;
  endtask

  task automatic test_simultaneous;
    do_reset();
    A = 2'd1; B = 2'd1; Op = 4'd1; Out = 8'h01;
    arm = 1'b1;
    step();
    repeat (3) step();
    A = 2'd3;
    flush = 1'b1;
    step();
    flush = 1'b0;
    total++;
    if (v10 !== 1'b1 || d10 !== 24'h510100) begin
      bad++;
      $display("FAIL simul_record got v=%b d=%h exp v=1 d=510100", v10, d10);
    end
    rec_ready = 1'b1;
    step();
    rec_ready = 1'b0;
    total++;
    if (v10 !== 1'b0) begin
      bad++;
      $display("FAIL simul_one got=%b exp=0", v10);
    end
    step();
    total++;
    if (v10 !== 1'b0) begin
      bad++;
      $display("FAIL simul_no_echo got=%b exp=0", v10);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_flush_disarm();
    test_simultaneous();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
